// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI register-file peripheral.
// Builds with SPI_READBACK_EN undefined by default; the macro itself is consumed in spi_regfile_periph.
package spi_regfile_pkg;

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      SHIFT     = 2'd2,
      COMMIT    = 2'd3
   } spi_state_e;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   // Frame is one R/W bit, then the address field, then the data field.
   function automatic int frame_w(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input.
// Provides the synchronised level plus single-cycle rise and fall pulses.
module spi_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_in};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral in front of a small control-register file; writes commit on ncs release.
// Optional readback path is enabled by defining SPI_READBACK_EN.
module spi_regfile_periph
   import spi_regfile_pkg::*;
#(
   parameter int                ADDR_W      = 7,
   parameter int                DATA_W      = 8,
   parameter int                NUM_REGS    = 5,
   parameter int                SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sclk,
   input  logic                       copi,
   input  logic                       ncs,
   output logic                       cipo,
   output logic                       cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0] regs_o,
   output logic                       wr_strobe_o,
   output logic [ADDR_W-1:0]          wr_addr_o,
   output logic                       err_o,
   output spi_state_e                 dbg_state
);

   localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
   localparam int CNT_W   = $clog2(FRAME_W + 2);
   localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

   logic sclk_s, sclk_rise, sclk_fall;
   logic ncs_s, ncs_rise, ncs_fall;
   logic [SYNC_STAGES-1:0] copi_sync_q;
   logic copi_s;

   spi_state_e state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [FRAME_W-1:0] shift_q;
   logic [DATA_W-1:0]  regs_q [NUM_REGS];

   logic               frm_rw;
   logic [ADDR_W-1:0]  frm_addr;
   logic [DATA_W-1:0]  frm_data;

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk(clk), .rst_n(rst_n), .async_in(sclk),
      .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ncs_sync (
      .clk(clk), .rst_n(rst_n), .async_in(ncs),
      .level(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
   );

   // copi shares the sclk chain depth so its level lines up with sclk_rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) copi_sync_q <= '0;
      else        copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
   end
   assign copi_s = copi_sync_q[SYNC_STAGES-1];

   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return 32'(a) < NUM_REGS;
   endfunction

   assign frm_rw   = shift_q[FRAME_W-1];
   assign frm_addr = shift_q[FRAME_W-2 -: ADDR_W];
   assign frm_data = shift_q[DATA_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= WAIT_IDLE;
      else        state_q <= state_d;
   end

   // Level-based ncs tests let a fall that lands during COMMIT start the next frame from IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_IDLE: if (ncs_s)  state_d = IDLE;
         IDLE:      if (!ncs_s) state_d = SHIFT;
         SHIFT:     if (ncs_s)  state_d = COMMIT;
         COMMIT:                state_d = IDLE;
         default:               state_d = WAIT_IDLE;
      endcase
   end

   assign dbg_state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         shift_q     <= '0;
         wr_strobe_o <= 1'b0;
         wr_addr_o   <= '0;
         err_o       <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      end else begin
         wr_strobe_o <= 1'b0;
         err_o       <= 1'b0;
         case (state_q)
            IDLE: if (!ncs_s) begin
               cnt_q   <= '0;
               shift_q <= '0;
            end
            SHIFT: if (sclk_rise && !ncs_s) begin
               shift_q <= {shift_q[FRAME_W-2:0], copi_s};
               if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
            end
            COMMIT: if (cnt_q != '0) begin
               if (cnt_q != CNT_FULL) begin
                  err_o <= 1'b1;
               end else if (frm_rw == RW_WRITE) begin
                  if (addr_ok(frm_addr)) begin
                     regs_q[frm_addr[IDX_W-1:0]] <= frm_data;
                     wr_strobe_o                  <= 1'b1;
                     wr_addr_o                    <= frm_addr;
                  end else begin
                     err_o <= 1'b1;
                  end
               end else begin
`ifdef SPI_READBACK_EN
                  if (!addr_ok(frm_addr)) err_o <= 1'b1;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      regs_o = '0;
      for (int i = 0; i < NUM_REGS; i++) regs_o[i*DATA_W +: DATA_W] = regs_q[i];
   end

`ifdef SPI_READBACK_EN
   logic [DATA_W-1:0] out_q;
   logic              cipo_q;
   logic [ADDR_W:0]   hdr_next;

   // Header as it will stand once the current sclk rise has been shifted in.
   assign hdr_next = {shift_q[ADDR_W-1:0], copi_s};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= '0;
         cipo_q <= 1'b0;
      end else if (ncs_s) begin
         out_q  <= '0;
         cipo_q <= 1'b0;
      end else if (state_q == SHIFT) begin
         if (sclk_rise && cnt_q == CNT_W'(ADDR_W)) begin
            if (hdr_next[ADDR_W] == RW_READ && addr_ok(hdr_next[ADDR_W-1:0]))
               out_q <= regs_q[hdr_next[IDX_W-1:0]];
            else
               out_q <= '0;
         end else if (sclk_fall) begin
            cipo_q <= out_q[DATA_W-1];
            out_q  <= {out_q[DATA_W-2:0], 1'b0};
         end
      end
   end

   assign cipo    = cipo_q;
   assign cipo_oe = ~ncs_s && (state_q != WAIT_IDLE);

   logic unused_edges;
   assign unused_edges = ncs_rise ^ ncs_fall ^ sclk_s;
`else
   assign cipo    = 1'b0;
   assign cipo_oe = 1'b0;

   logic unused_edges;
   assign unused_edges = ncs_rise ^ ncs_fall ^ sclk_s ^ sclk_fall;
`endif

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Directed bench for spi_regfile_periph: bit-banged SPI frames at sclk = clk/8.
// Readback steps are selected with SPI_READBACK_EN, matching the DUT build.
module tb_spi_regfile_periph;
   import spi_regfile_pkg::*;

   localparam int HALF = 40;
   localparam int GAP  = 160;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sclk = 1'b0;
   logic        copi = 1'b0;
   logic        ncs = 1'b1;
   logic        cipo, cipo_oe, wr_strobe_o, err_o;
   logic [39:0] regs_o;
   logic [6:0]  wr_addr_o;
   spi_state_e  dbg_state;

   int n_total = 0;
   int n_pass = 0;
   int n_fail = 0;
   int strobe_cnt = 0;
   int err_cnt = 0;
   int s0, e0;
   logic [15:0] rx;
   logic        oe_seen;

   always #5 clk = ~clk;

   spi_regfile_periph dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
      .cipo(cipo), .cipo_oe(cipo_oe), .regs_o(regs_o),
      .wr_strobe_o(wr_strobe_o), .wr_addr_o(wr_addr_o), .err_o(err_o),
      .dbg_state(dbg_state)
   );

   always @(negedge clk) begin
      if (wr_strobe_o === 1'b1) strobe_cnt++;
      if (err_o === 1'b1) err_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bits(input logic [31:0] val, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         copi = val[i];
         #HALF;
         rx      = {rx[14:0], cipo};
         oe_seen = cipo_oe;
         sclk    = 1'b1;
         #HALF;
         sclk = 1'b0;
      end
   endtask

   task automatic frame(input logic [31:0] val, input int nbits);
      ncs = 1'b0;
      rx  = '0;
      #HALF;
      send_bits(val, nbits);
      #HALF;
      ncs = 1'b1;
      #GAP;
   endtask

   task automatic mark();
      s0 = strobe_cnt;
      e0 = err_cnt;
   endtask

   initial begin
      #23;
      chk("rst_regs", regs_o, 40'h0);
      chk("rst_strobe", wr_strobe_o, 1'b0);
      chk("rst_err", err_o, 1'b0);
      chk("rst_cipo", cipo, 1'b0);
      chk("rst_cipo_oe", cipo_oe, 1'b0);
      chk("rst_wr_addr", wr_addr_o, 7'h0);
      chk("rst_state", dbg_state, WAIT_IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_after_rst", dbg_state, IDLE);

      // 1: plain write to reg 2
      mark();
      frame(32'h82A5, 16);
      chk("t1_regs", regs_o, 40'h00_00_A5_00_00);
      chk("t1_strobes", strobe_cnt - s0, 1);
      chk("t1_errs", err_cnt - e0, 0);
      chk("t1_wr_addr", wr_addr_o, 7'd2);

      // 2: out-of-range address
      mark();
      frame(32'h8A11, 16);
      chk("t2_regs", regs_o, 40'h00_00_A5_00_00);
      chk("t2_strobes", strobe_cnt - s0, 0);
      chk("t2_errs", err_cnt - e0, 1);

      // 3: short and overrun frames
      mark();
      frame(32'h855, 12);
      frame({15'h0, 16'h8133, 1'b1}, 17);
      chk("t3_regs", regs_o, 40'h00_00_A5_00_00);
      chk("t3_strobes", strobe_cnt - s0, 0);
      chk("t3_errs", err_cnt - e0, 2);

      // 4: reset mid-frame, remainder of the frame ignored
      ncs = 1'b0;
      #HALF;
      send_bits(32'h8377 >> 10, 6);
      rst_n = 1'b0;
      #20;
      chk("t4_async_clear", regs_o, 40'h0);
      chk("t4_rst_state", dbg_state, WAIT_IDLE);
      rst_n = 1'b1;
      #20;
      mark();
      chk("t4_wait_idle", dbg_state, WAIT_IDLE);
      send_bits(32'h8377 & 32'h3FF, 10);
      #HALF;
      ncs = 1'b1;
      #GAP;
      chk("t4_regs_lost", regs_o, 40'h0);
      chk("t4_strobes", strobe_cnt - s0, 0);
      chk("t4_errs", err_cnt - e0, 0);
      chk("t4_wr_addr", wr_addr_o, 7'h0);
      chk("t4_state_idle", dbg_state, IDLE);
      mark();
      frame(32'h8377, 16);
      chk("t4_regs_new", regs_o, 40'h00_77_00_00_00);
      chk("t4_wr_addr_new", wr_addr_o, 7'd3);
      chk("t4_strobes_new", strobe_cnt - s0, 1);

      // 5: back-to-back writes with a two-period ncs gap
      mark();
      frame(32'h8011, 16);
      frame(32'h8122, 16);
      chk("t5_regs", regs_o, 40'h00_77_00_22_11);
      chk("t5_strobes", strobe_cnt - s0, 2);
      chk("t5_errs", err_cnt - e0, 0);
      chk("t5_wr_addr", wr_addr_o, 7'd1);

`ifdef SPI_READBACK_EN
      // 6: write then read back, then read an unimplemented address
      mark();
      frame(32'h813C, 16);
      chk("t6_regs", regs_o, 40'h00_77_00_3C_11);
      frame(32'h0100, 16);
      chk("t6_rd_data", rx[7:0], 8'h3C);
      chk("t6_rd_oe", oe_seen, 1'b1);
      chk("t6_rd_strobes", strobe_cnt - s0, 1);
      chk("t6_rd_errs", err_cnt - e0, 0);
      chk("t6_oe_idle", cipo_oe, 1'b0);
      mark();
      frame(32'h0900, 16);
      chk("t6_bad_rd_data", rx[7:0], 8'h00);
      chk("t6_bad_rd_errs", err_cnt - e0, 1);
      chk("t6_bad_rd_strobes", strobe_cnt - s0, 0);
      chk("t6_regs_after", regs_o, 40'h00_77_00_3C_11);
`else
      // 6: read frames are discarded silently without readback
      mark();
      frame(32'h0100, 16);
      chk("t6_rd_cipo", rx, 16'h0);
      chk("t6_rd_oe", oe_seen, 1'b0);
      chk("t6_rd_errs", err_cnt - e0, 0);
      chk("t6_rd_strobes", strobe_cnt - s0, 0);
      chk("t6_regs", regs_o, 40'h00_77_00_22_11);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
